// File: rtl/matrix_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// matrix_seq_ctrl : job sequencer and single-word result reader for the
//                   matrix datapath (load X / compute per column / read SRAM)
// Revision: 1.0
// ==========================================================================
module matrix_seq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int N_COLS         = 4,
  parameter int CALC_TIMEOUT   = 64,
  parameter int READ_TIMEOUT   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [31:0]               in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      rd_req,
  input  logic [APB_ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]               rd_data,
  output logic                      rd_valid,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      load_en,
  output logic                      valid_input,
  output logic [31:0]               PWDATA,
  output logic                      ALU_en,
  output logic [1:0]                col_counter,
  output logic                      read_n,
  output logic [APB_ADDR_WIDTH-1:0] r_addr,
  input  logic                      load_done,
  input  logic                      cal_finish,
  input  logic                      ry,
  input  logic [31:0]               data_out
);

  localparam int CNT_MAX = (CALC_TIMEOUT > READ_TIMEOUT) ? CALC_TIMEOUT : READ_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [1:0]       LAST_COL  = 2'(N_COLS - 1);
  localparam logic [CNT_W-1:0] CALC_LAST = CNT_W'(CALC_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] READ_LAST = CNT_W'(READ_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_DONE = 3'd3,
    S_READ = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  state_e                      state_q, state_d;
  state_e                      ret_q, ret_d;
  logic [1:0]                  col_q, col_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        rd_valid_q, rd_valid_d;
  logic [31:0]                 rd_data_q, rd_data_d;
  logic [APB_ADDR_WIDTH-1:0]   r_addr_q, r_addr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ret_q      <= S_IDLE;
      col_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      r_addr_q   <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      col_q      <= col_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      r_addr_q   <= r_addr_d;
    end
  end

  // cnt is the per-visit cycle counter for CALC/READ; it restarts on every state change.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    col_d      = col_q;
    cnt_d      = '0;
    done_d     = done_q;
    err_d      = err_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    r_addr_d   = r_addr_q;

    if (abort) begin
      state_d = S_IDLE;
      col_d   = '0;
      done_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d = S_LOAD;
            col_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end else if (rd_req) begin
            state_d  = S_READ;
            ret_d    = state_q;
            r_addr_d = rd_addr;
          end
        end
        S_ERR: begin
          if (start) begin
            state_d = S_LOAD;
            col_d   = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
        S_LOAD: begin
          if (load_done) state_d = S_CALC;
        end
        S_CALC: begin
          if (cal_finish) begin
            if (col_q == LAST_COL) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              col_d   = col_q + 2'd1;
              state_d = S_LOAD;
            end
          end else if (cnt_q == CALC_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_READ: begin
          // The strobe cycle (cnt==0) never accepts ry; the SRAM cannot answer that fast.
          if (ry && (cnt_q != '0)) begin
            state_d    = ret_q;
            rd_data_d  = data_out;
            rd_valid_d = 1'b1;
          end else if (cnt_q == READ_LAST) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy        = (state_q == S_LOAD) || (state_q == S_CALC);
  assign load_en     = (state_q == S_LOAD);
  assign in_ready    = load_en & ~load_done;
  assign valid_input = in_valid & in_ready;
  assign PWDATA      = load_en ? in_data : 32'd0;
  assign ALU_en      = (state_q == S_CALC);
  assign read_n      = ~((state_q == S_READ) && (cnt_q == '0));
  assign r_addr      = r_addr_q;
  assign col_counter = col_q;
  assign done        = done_q;
  assign err         = err_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_seq_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_matrix_seq_ctrl : self-checking bench for matrix_seq_ctrl
// Revision: 1.0
// ==========================================================================
module tb_matrix_seq_ctrl;

  logic        clk, rst, start, abort;
  logic [31:0] in_data;
  logic        in_valid, in_ready;
  logic        rd_req;
  logic [11:0] rd_addr;
  logic [31:0] rd_data;
  logic        rd_valid, busy, done, err, load_en, valid_input;
  logic [31:0] PWDATA;
  logic        ALU_en;
  logic [1:0]  col_counter;
  logic        read_n;
  logic [11:0] r_addr;
  logic        load_done, cal_finish, ry;
  logic [31:0] data_out;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] wq[$];
  logic [31:0] rq[$];
  logic [31:0] mon_exp;

  matrix_seq_ctrl #(
    .APB_ADDR_WIDTH(12), .N_COLS(4), .CALC_TIMEOUT(64), .READ_TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .done(done), .err(err),
    .load_en(load_en), .valid_input(valid_input), .PWDATA(PWDATA),
    .ALU_en(ALU_en), .col_counter(col_counter), .read_n(read_n), .r_addr(r_addr),
    .load_done(load_done), .cal_finish(cal_finish), .ry(ry), .data_out(data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Scoreboard: forwarded X words and read results are popped as the DUT emits them.
  always @(negedge clk) begin
    if (!rst && valid_input) begin
      vectors++;
      if (wq.size() == 0) begin
        miscompares++;
        $display("FAIL fwd_word unexpected valid_input PWDATA=%h", PWDATA);
      end else begin
        mon_exp = wq.pop_front();
        if (PWDATA !== mon_exp) begin
          miscompares++;
          $display("FAIL fwd_word got=%h exp=%h", PWDATA, mon_exp);
        end
      end
    end
    if (!rst && rd_valid) begin
      vectors++;
      if (rq.size() == 0) begin
        miscompares++;
        $display("FAIL rd_result unexpected rd_valid rd_data=%h", rd_data);
      end else begin
        mon_exp = rq.pop_front();
        if (rd_data !== mon_exp) begin
          miscompares++;
          $display("FAIL rd_result got=%h exp=%h", rd_data, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_load(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = $urandom; load_done = 1'b0;
      wq.push_back(in_data);
      tick();
    end
    in_valid = 1'b0; load_done = 1'b1;
    tick();
    load_done = 1'b0;
  endtask

  task automatic drive_calc(input int n);
    repeat (n - 1) tick();
    cal_finish = 1'b1;
    tick();
    cal_finish = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; in_data = 32'h1234_5678; in_valid = 0;
    rd_req = 0; rd_addr = 12'h0; load_done = 0; cal_finish = 0; ry = 0; data_out = 0;
    repeat (2) tick();
    vectors++;
    if ({busy, done, err, load_en, valid_input, in_ready, ALU_en, rd_valid, read_n, col_counter} !== 11'b00000000100
        || rd_data !== 32'd0 || r_addr !== 12'd0 || PWDATA !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state got=%b rd_data=%h r_addr=%h PWDATA=%h exp=00000000100/0/0/0",
               {busy, done, err, load_en, valid_input, in_ready, ALU_en, rd_valid, read_n, col_counter},
               rd_data, r_addr, PWDATA);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_full_job();
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (load_en !== 1'b1 || busy !== 1'b1 || col_counter !== 2'(c)) begin
        miscompares++;
        $display("FAIL load_entry col%0d got load_en=%b busy=%b col=%0d exp 1 1 %0d",
                 c, load_en, busy, col_counter, c);
      end
      for (int i = 0; i < 6; i++) begin
        in_valid = 1'b1; in_data = $urandom; load_done = 1'b0;
        wq.push_back(in_data);
        tick();
      end
      in_data = $urandom; load_done = 1'b1;
      #1;
      vectors++;
      if (in_ready !== 1'b0 || valid_input !== 1'b0) begin
        miscompares++;
        $display("FAIL load_done_block got in_ready=%b valid_input=%b exp 0 0", in_ready, valid_input);
      end
      tick();
      in_valid = 1'b0; load_done = 1'b0;
      vectors++;
      if (ALU_en !== 1'b1 || load_en !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
        miscompares++;
        $display("FAIL calc_entry got ALU_en=%b load_en=%b busy=%b done=%b exp 1 0 1 0",
                 ALU_en, load_en, busy, done);
      end
      repeat (9) tick();
      cal_finish = 1'b1; tick(); cal_finish = 1'b0;
      vectors++;
      if (ALU_en !== 1'b0) begin
        miscompares++;
        $display("FAIL alu_after_calc got=%b exp=0", ALU_en);
      end
      if (c < 3) begin
        vectors++;
        if (col_counter !== 2'(c + 1) || load_en !== 1'b1) begin
          miscompares++;
          $display("FAIL col_step got col=%0d load_en=%b exp col=%0d load_en=1",
                   col_counter, load_en, c + 1);
        end
      end else begin
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || col_counter !== 2'd3 || err !== 1'b0) begin
          miscompares++;
          $display("FAIL job_done got done=%b busy=%b col=%0d err=%b exp 1 0 3 0",
                   done, busy, col_counter, err);
        end
      end
    end
  endtask

  task automatic test_read();
    rd_addr = 12'h005; rd_req = 1'b1; rq.push_back(32'hDEAD_BEEF);
    tick(); rd_req = 1'b0; rd_addr = 12'h0;
    vectors++;
    if (read_n !== 1'b0 || r_addr !== 12'h005 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL read_strobe got read_n=%b r_addr=%h busy=%b exp 0 005 0", read_n, r_addr, busy);
    end
    ry = 1'b1; data_out = 32'h0BAD_0BAD;
    tick(); ry = 1'b0; data_out = 32'h0;
    vectors++;
    if (read_n !== 1'b1 || rd_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL read_cycle2 got read_n=%b rd_valid=%b exp 1 0", read_n, rd_valid);
    end
    rd_req = 1'b1; rd_addr = 12'h3FF;
    tick(); rd_req = 1'b0; rd_addr = 12'h0;
    ry = 1'b1; data_out = 32'hDEAD_BEEF;
    tick(); ry = 1'b0; data_out = 32'h0;
    vectors++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hDEAD_BEEF || done !== 1'b1) begin
      miscompares++;
      $display("FAIL read_capture got rd_valid=%b rd_data=%h done=%b exp 1 deadbeef 1",
               rd_valid, rd_data, done);
    end
    tick();
    vectors++;
    if (rd_valid !== 1'b0 || rd_data !== 32'hDEAD_BEEF || read_n !== 1'b1 || r_addr !== 12'h005) begin
      miscompares++;
      $display("FAIL read_hold got rd_valid=%b rd_data=%h read_n=%b r_addr=%h exp 0 deadbeef 1 005",
               rd_valid, rd_data, read_n, r_addr);
    end
    repeat (9) tick();
    vectors++;
    if (err !== 1'b0 || done !== 1'b1) begin
      miscompares++;
      $display("FAIL read_return got err=%b done=%b exp 0 1", err, done);
    end
  endtask

  task automatic test_read_timeout();
    rd_addr = 12'h07A; rd_req = 1'b1;
    tick(); rd_req = 1'b0; rd_addr = 12'h0;
    vectors++;
    if (read_n !== 1'b0 || r_addr !== 12'h07A) begin
      miscompares++;
      $display("FAIL rto_strobe got read_n=%b r_addr=%h exp 0 07a", read_n, r_addr);
    end
    repeat (7) tick();
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL rto_early got err=%b exp=0", err);
    end
    tick();
    vectors++;
    if (err !== 1'b1 || read_n !== 1'b1) begin
      miscompares++;
      $display("FAIL rto_err got err=%b read_n=%b exp 1 1", err, read_n);
    end
    rd_addr = 12'h123; rd_req = 1'b1;
    tick(); rd_req = 1'b0; rd_addr = 12'h0;
    vectors++;
    if (read_n !== 1'b1 || r_addr !== 12'h07A || err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_ignores_rd got read_n=%b r_addr=%h err=%b exp 1 07a 1", read_n, r_addr, err);
    end
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (err !== 1'b0 || done !== 1'b0 || col_counter !== 2'd0 || load_en !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear got err=%b done=%b col=%0d load_en=%b exp 0 0 0 1",
               err, done, col_counter, load_en);
    end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 8; i++) begin
      in_valid = (i % 2 == 0); in_data = $urandom; load_done = 1'b0;
      if (in_valid) wq.push_back(in_data);
      #1;
      vectors++;
      if (valid_input !== in_valid || (in_valid && PWDATA !== in_data)) begin
        miscompares++;
        $display("FAIL backpressure beat%0d got valid_input=%b PWDATA=%h exp %b %h",
                 i, valid_input, PWDATA, in_valid, in_data);
      end
      tick();
    end
    in_valid = 1'b1; in_data = $urandom; load_done = 1'b1;
    #1;
    vectors++;
    if (valid_input !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_load_done got valid_input=%b in_ready=%b exp 0 0", valid_input, in_ready);
    end
    tick();
    in_valid = 1'b0; load_done = 1'b0;
  endtask

  task automatic test_calc_timeout();
    repeat (63) tick();
    vectors++;
    if (err !== 1'b0 || ALU_en !== 1'b1) begin
      miscompares++;
      $display("FAIL cto_early got err=%b ALU_en=%b exp 0 1", err, ALU_en);
    end
    tick();
    vectors++;
    if (err !== 1'b1 || ALU_en !== 1'b0 || busy !== 1'b0 || load_en !== 1'b0 || read_n !== 1'b1
        || col_counter !== 2'd0) begin
      miscompares++;
      $display("FAIL cto_err got err=%b ALU_en=%b busy=%b load_en=%b read_n=%b col=%0d exp 1 0 0 0 1 0",
               err, ALU_en, busy, load_en, read_n, col_counter);
    end
  endtask

  task automatic test_abort();
    start = 1'b1; tick(); start = 1'b0;
    drive_load(2); drive_calc(3);
    drive_load(2); drive_calc(3);
    drive_load(2);
    tick(); tick();
    vectors++;
    if (ALU_en !== 1'b1 || col_counter !== 2'd2) begin
      miscompares++;
      $display("FAIL abort_setup got ALU_en=%b col=%0d exp 1 2", ALU_en, col_counter);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    vectors++;
    if (ALU_en !== 1'b0 || col_counter !== 2'd0 || busy !== 1'b0 || load_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_calc got ALU_en=%b col=%0d busy=%b load_en=%b exp 0 0 0 0",
               ALU_en, col_counter, busy, load_en);
    end
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_load(1); drive_calc(2);
    end
    drive_load(1);
    abort = 1'b1; cal_finish = 1'b1; tick(); abort = 1'b0; cal_finish = 1'b0;
    vectors++;
    if (done !== 1'b0 || col_counter !== 2'd0 || busy !== 1'b0 || ALU_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_wins got done=%b col=%0d busy=%b ALU_en=%b exp 0 0 0 0",
               done, col_counter, busy, ALU_en);
    end
  endtask

  task automatic test_reset_mid_load();
    start = 1'b1; tick(); start = 1'b0;
    drive_load(1);
    tick();
    start = 1'b1; tick(); start = 1'b0;
    vectors++;
    if (ALU_en !== 1'b1 || load_en !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_calc got ALU_en=%b load_en=%b exp 1 0", ALU_en, load_en);
    end
    cal_finish = 1'b1; tick(); cal_finish = 1'b0;
    start = 1'b1; in_valid = 1'b1; in_data = $urandom; wq.push_back(in_data);
    tick(); start = 1'b0; in_valid = 1'b0;
    vectors++;
    if (load_en !== 1'b1 || col_counter !== 2'd1) begin
      miscompares++;
      $display("FAIL start_in_load got load_en=%b col=%0d exp 1 1", load_en, col_counter);
    end
    rst = 1'b1; in_data = 32'hA5A5_5A5A;
    tick();
    vectors++;
    if ({busy, done, err, load_en, valid_input, in_ready, ALU_en, rd_valid, read_n, col_counter} !== 11'b00000000100
        || rd_data !== 32'd0 || r_addr !== 12'd0 || PWDATA !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_mid_load got=%b rd_data=%h r_addr=%h PWDATA=%h exp=00000000100/0/0/0",
               {busy, done, err, load_en, valid_input, in_ready, ALU_en, rd_valid, read_n, col_counter},
               rd_data, r_addr, PWDATA);
    end
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_full_job();
    test_read();
    test_read_timeout();
    test_backpressure();
    test_calc_timeout();
    test_abort();
    test_reset_mid_load();
    vectors++;
    if (wq.size() != 0 || rq.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got words=%0d reads=%0d pending exp 0 0", wq.size(), rq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
